// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues one word read at a time, presents instruction + PC+4.
// Latency: request to fetch_valid is memory latency + 1 cycle; one instruction per 2 cycles at L=1.
// Backpressure: stall freezes the held instruction and suppresses the next request; redirect wins over stall.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] Instruction_out,
    output logic [31:0] PC4_out
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        discard;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    assign pc_plus4       = pc + 32'd4;
    assign target_aligned = branch_target & ~32'd3;

    // A HOLD cycle without stall consumes the instruction and overlaps the next request.
    always_comb begin
        imem_req = 1'b0;
        if (rst && !branch_taken)
            imem_req = (state == ISSUE) || ((state == HOLD) && !stall);
    end

    assign imem_addr = imem_req ? pc : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ISSUE;
            pc              <= RESET_PC;
            discard         <= 1'b0;
            fetch_valid     <= 1'b0;
            Instruction_out <= 32'd0;
            PC4_out         <= 32'd0;
        end else if (branch_taken) begin
            pc          <= target_aligned;
            fetch_valid <= 1'b0;
            if ((state == WAIT) && !imem_rvalid) begin
                // Response still in flight: remember to throw it away when it lands.
                discard <= 1'b1;
                state   <= WAIT;
            end else begin
                discard <= 1'b0;
                state   <= ISSUE;
            end
        end else begin
            case (state)
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= ISSUE;
                        end else begin
                            Instruction_out <= imem_rdata;
                            PC4_out         <= pc_plus4;
                            pc              <= pc_plus4;
                            fetch_valid     <= 1'b1;
                            state           <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        fetch_valid <= 1'b0;
                        state       <= WAIT;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

endmodule
